// File: rtl/axis_divider_unsigned_core.sv
// Iterative radix-2 restoring unsigned divider with AXI-Stream operand slots.
// One quotient bit per clock; the result is held on dout until it is accepted.
module axis_divider_unsigned_core #(
    parameter int unsigned WIDTH = 64
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 s_axis_divisor_tvalid,
    output logic                 s_axis_divisor_tready,
    input  logic [WIDTH-1:0]     s_axis_divisor_tdata,
    input  logic                 s_axis_dividend_tvalid,
    output logic                 s_axis_dividend_tready,
    input  logic [WIDTH-1:0]     s_axis_dividend_tdata,
    output logic                 m_axis_dout_tvalid,
    input  logic                 m_axis_dout_tready,
    output logic [2*WIDTH-1:0]   m_axis_dout_tdata,
    output logic                 m_axis_dout_tuser
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic               divisor_full, dividend_full;
    logic [WIDTH-1:0]   divisor_slot, dividend_slot;

    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   shift;
    logic [WIDTH-1:0]   den;
    logic [CW-1:0]      cnt;

    logic [WIDTH:0]     trial;
    logic [WIDTH:0]     diff;
    logic               q_bit;
    logic [WIDTH-1:0]   rem_step;
    logic [WIDTH-1:0]   shift_step;

    logic start, last_step, out_fire;

    assign s_axis_divisor_tready  = ~divisor_full;
    assign s_axis_dividend_tready = ~dividend_full;
    assign m_axis_dout_tvalid     = (state == DONE);

    assign start     = (state == IDLE) && divisor_full && dividend_full;
    assign last_step = (state == CALC) && (cnt == CW'(WIDTH - 1));
    assign out_fire  = (state == DONE) && m_axis_dout_tready;

    // The borrow of the (WIDTH+1)-bit subtraction doubles as the compare;
    // the running remainder never exceeds WIDTH bits, so only those are stored.
    always_comb begin
        trial      = {rem, shift[WIDTH-1]};
        diff       = trial - {1'b0, den};
        q_bit      = ~diff[WIDTH];
        rem_step   = q_bit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
        shift_step = {shift[WIDTH-2:0], q_bit};
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start)     state_next = CALC;
            CALC:    if (last_step) state_next = DONE;
            DONE:    if (out_fire)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            divisor_full  <= 1'b0;
            dividend_full <= 1'b0;
            divisor_slot  <= '0;
            dividend_slot <= '0;
        end else if (start) begin
            divisor_full  <= 1'b0;
            dividend_full <= 1'b0;
        end else begin
            if (s_axis_divisor_tvalid && !divisor_full) begin
                divisor_full <= 1'b1;
                divisor_slot <= s_axis_divisor_tdata;
            end
            if (s_axis_dividend_tvalid && !dividend_full) begin
                dividend_full <= 1'b1;
                dividend_slot <= s_axis_dividend_tdata;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            rem               <= '0;
            shift             <= '0;
            den               <= '0;
            cnt               <= '0;
            m_axis_dout_tdata <= '0;
            m_axis_dout_tuser <= 1'b0;
        end else if (start) begin
            rem   <= '0;
            shift <= dividend_slot;
            den   <= divisor_slot;
            cnt   <= '0;
        end else if (state == CALC) begin
            rem   <= rem_step;
            shift <= shift_step;
            cnt   <= cnt + CW'(1);
            if (last_step) begin
                m_axis_dout_tdata <= {shift_step, rem_step};
                m_axis_dout_tuser <= (den == '0);
            end
        end
    end

endmodule

// File: tb/tb_axis_divider_unsigned_core.sv
// Directed bench for axis_divider_unsigned_core: latency, results, ordering,
// output back-pressure and mid-operation reset.
module tb_axis_divider_unsigned_core;

    localparam int W = 64;

    logic           clock;
    logic           resetn;
    logic           s_axis_divisor_tvalid;
    logic           s_axis_divisor_tready;
    logic [W-1:0]   s_axis_divisor_tdata;
    logic           s_axis_dividend_tvalid;
    logic           s_axis_dividend_tready;
    logic [W-1:0]   s_axis_dividend_tdata;
    logic           m_axis_dout_tvalid;
    logic           m_axis_dout_tready;
    logic [2*W-1:0] m_axis_dout_tdata;
    logic           m_axis_dout_tuser;

    int compared   = 0;
    int mismatched = 0;

    axis_divider_unsigned_core #(.WIDTH(W)) dut (
        .clock                  (clock),
        .resetn                 (resetn),
        .s_axis_divisor_tvalid  (s_axis_divisor_tvalid),
        .s_axis_divisor_tready  (s_axis_divisor_tready),
        .s_axis_divisor_tdata   (s_axis_divisor_tdata),
        .s_axis_dividend_tvalid (s_axis_dividend_tvalid),
        .s_axis_dividend_tready (s_axis_dividend_tready),
        .s_axis_dividend_tdata  (s_axis_dividend_tdata),
        .m_axis_dout_tvalid     (m_axis_dout_tvalid),
        .m_axis_dout_tready     (m_axis_dout_tready),
        .m_axis_dout_tdata      (m_axis_dout_tdata),
        .m_axis_dout_tuser      (m_axis_dout_tuser)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Waits (bounded) for both slots free, then presents both operands for one edge.
    task automatic send_both(input logic [W-1:0] dvd, input logic [W-1:0] dvs);
        for (int i = 0; i < 200 && !(s_axis_divisor_tready && s_axis_dividend_tready); i++) begin
            @(posedge clock); #1;
        end
        s_axis_dividend_tvalid = 1'b1;
        s_axis_dividend_tdata  = dvd;
        s_axis_divisor_tvalid  = 1'b1;
        s_axis_divisor_tdata   = dvs;
        @(posedge clock); #1;
        s_axis_dividend_tvalid = 1'b0;
        s_axis_divisor_tvalid  = 1'b0;
    endtask

    // Counts edges until tvalid is seen; 200 means it never came.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (lat < 200) begin
            @(posedge clock); #1;
            lat++;
            if (m_axis_dout_tvalid) break;
        end
    endtask

    task automatic consume();
        m_axis_dout_tready = 1'b1;
        @(posedge clock); #1;
        m_axis_dout_tready = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(posedge clock);
        #1 resetn = 1'b1;
        compared++; if (s_axis_divisor_tready !== 1'b1) begin mismatched++; $display("FAIL reset_divisor_tready got=%b want=1", s_axis_divisor_tready); end
        compared++; if (s_axis_dividend_tready !== 1'b1) begin mismatched++; $display("FAIL reset_dividend_tready got=%b want=1", s_axis_dividend_tready); end
        compared++; if (m_axis_dout_tvalid !== 1'b0) begin mismatched++; $display("FAIL reset_tvalid got=%b want=0", m_axis_dout_tvalid); end
        compared++; if (m_axis_dout_tdata !== '0) begin mismatched++; $display("FAIL reset_tdata got=%h want=0", m_axis_dout_tdata); end
        compared++; if (m_axis_dout_tuser !== 1'b0) begin mismatched++; $display("FAIL reset_tuser got=%b want=0", m_axis_dout_tuser); end
    endtask

    task automatic test_basic();
        int lat;
        logic [2*W-1:0] exp;
        exp = {64'd14, 64'd2};
        send_both(64'd100, 64'd7);
        wait_valid(lat);
        compared++; if (lat !== 65) begin mismatched++; $display("FAIL basic_latency got=%0d want=65", lat); end
        compared++; if (m_axis_dout_tdata !== exp) begin mismatched++; $display("FAIL basic_tdata got=%h want=%h", m_axis_dout_tdata, exp); end
        compared++; if (m_axis_dout_tuser !== 1'b0) begin mismatched++; $display("FAIL basic_tuser got=%b want=0", m_axis_dout_tuser); end
        consume();
        compared++; if (m_axis_dout_tvalid !== 1'b0) begin mismatched++; $display("FAIL basic_tvalid_drop got=%b want=0", m_axis_dout_tvalid); end
        compared++; if (m_axis_dout_tdata !== exp) begin mismatched++; $display("FAIL basic_tdata_held got=%h want=%h", m_axis_dout_tdata, exp); end
    endtask

    task automatic test_vectors();
        int lat;
        logic [2*W-1:0] exp;
        exp = {64'hFFFF_FFFF_FFFF_FFFF, 64'd0};
        send_both(64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        wait_valid(lat);
        compared++; if (m_axis_dout_tdata !== exp) begin mismatched++; $display("FAIL max_div1_tdata got=%h want=%h", m_axis_dout_tdata, exp); end
        consume();
        exp = {64'd0, 64'd5};
        send_both(64'd5, 64'd9);
        wait_valid(lat);
        compared++; if (m_axis_dout_tdata !== exp) begin mismatched++; $display("FAIL small_tdata got=%h want=%h", m_axis_dout_tdata, exp); end
        compared++; if (m_axis_dout_tuser !== 1'b0) begin mismatched++; $display("FAIL small_tuser got=%b want=0", m_axis_dout_tuser); end
        consume();
    endtask

    task automatic test_div_zero();
        int lat;
        logic [2*W-1:0] exp;
        exp = {64'hFFFF_FFFF_FFFF_FFFF, 64'h1234};
        send_both(64'h1234, 64'd0);
        wait_valid(lat);
        compared++; if (lat !== 65) begin mismatched++; $display("FAIL divzero_latency got=%0d want=65", lat); end
        compared++; if (m_axis_dout_tdata !== exp) begin mismatched++; $display("FAIL divzero_tdata got=%h want=%h", m_axis_dout_tdata, exp); end
        compared++; if (m_axis_dout_tuser !== 1'b1) begin mismatched++; $display("FAIL divzero_tuser got=%b want=1", m_axis_dout_tuser); end
        consume();
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [2*W-1:0] exp1, exp2;
        exp1 = {64'd30, 64'd10};
        exp2 = {64'hDEAD_BEE, 64'hF};
        s_axis_divisor_tvalid = 1'b1;
        s_axis_divisor_tdata  = 64'd33;
        @(posedge clock); #1;
        s_axis_divisor_tvalid = 1'b0;
        compared++; if (s_axis_divisor_tready !== 1'b0) begin mismatched++; $display("FAIL b2b_divisor_slot_full got=%b want=0", s_axis_divisor_tready); end
        compared++; if (s_axis_dividend_tready !== 1'b1) begin mismatched++; $display("FAIL b2b_dividend_slot_free got=%b want=1", s_axis_dividend_tready); end
        repeat (10) @(posedge clock);
        #1;
        compared++; if (m_axis_dout_tvalid !== 1'b0 || s_axis_divisor_tready !== 1'b0) begin mismatched++; $display("FAIL b2b_wait_dividend got=%b/%b want=0/0", m_axis_dout_tvalid, s_axis_divisor_tready); end
        s_axis_dividend_tvalid = 1'b1;
        s_axis_dividend_tdata  = 64'd1000;
        @(posedge clock); #1;
        s_axis_dividend_tvalid = 1'b0;
        @(posedge clock); #1;
        compared++; if ({s_axis_divisor_tready, s_axis_dividend_tready} !== 2'b11) begin mismatched++; $display("FAIL b2b_slots_emptied got=%b want=11", {s_axis_divisor_tready, s_axis_dividend_tready}); end
        repeat (3) @(posedge clock);
        #1;
        send_both(64'hDEAD_BEEF, 64'h10);
        compared++; if ({s_axis_divisor_tready, s_axis_dividend_tready} !== 2'b00) begin mismatched++; $display("FAIL b2b_second_pair_held got=%b want=00", {s_axis_divisor_tready, s_axis_dividend_tready}); end
        wait_valid(lat);
        compared++; if (lat !== 60) begin mismatched++; $display("FAIL b2b_first_latency got=%0d want=60", lat); end
        compared++; if (m_axis_dout_tdata !== exp1) begin mismatched++; $display("FAIL b2b_first_tdata got=%h want=%h", m_axis_dout_tdata, exp1); end
        compared++; if ({s_axis_divisor_tready, s_axis_dividend_tready} !== 2'b00) begin mismatched++; $display("FAIL b2b_slots_full_in_done got=%b want=00", {s_axis_divisor_tready, s_axis_dividend_tready}); end
        consume();
        compared++; if ({m_axis_dout_tvalid, s_axis_divisor_tready, s_axis_dividend_tready} !== 3'b000) begin mismatched++; $display("FAIL b2b_after_handshake got=%b want=000", {m_axis_dout_tvalid, s_axis_divisor_tready, s_axis_dividend_tready}); end
        @(posedge clock); #1;
        compared++; if ({s_axis_divisor_tready, s_axis_dividend_tready} !== 2'b11) begin mismatched++; $display("FAIL b2b_second_load got=%b want=11", {s_axis_divisor_tready, s_axis_dividend_tready}); end
        wait_valid(lat);
        compared++; if (lat !== 64) begin mismatched++; $display("FAIL b2b_second_latency got=%0d want=64", lat); end
        compared++; if (m_axis_dout_tdata !== exp2) begin mismatched++; $display("FAIL b2b_second_tdata got=%h want=%h", m_axis_dout_tdata, exp2); end
        consume();
    endtask

    task automatic test_backpressure();
        int lat;
        int bad = 0;
        logic [2*W-1:0] exp;
        exp = {64'd123, 64'd45};
        send_both(64'd12345, 64'd100);
        wait_valid(lat);
        compared++; if (m_axis_dout_tdata !== exp) begin mismatched++; $display("FAIL bp_tdata got=%h want=%h", m_axis_dout_tdata, exp); end
        for (int i = 0; i < 20; i++) begin
            @(posedge clock); #1;
            if (m_axis_dout_tvalid !== 1'b1 || m_axis_dout_tdata !== exp || m_axis_dout_tuser !== 1'b0) bad++;
        end
        compared++; if (bad !== 0) begin mismatched++; $display("FAIL bp_hold_stable got=%0d unstable cycles want=0", bad); end
        consume();
        compared++; if (m_axis_dout_tvalid !== 1'b0) begin mismatched++; $display("FAIL bp_single_transfer got=%b want=0", m_axis_dout_tvalid); end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            if (m_axis_dout_tvalid !== 1'b0) bad++;
        end
        compared++; if (bad !== 0) begin mismatched++; $display("FAIL bp_no_repeat got=%0d valid cycles want=0", bad); end
    endtask

    task automatic test_mid_reset();
        int lat;
        int stale = 0;
        logic [2*W-1:0] exp;
        exp = {64'd10, 64'd0};
        send_both(64'd999, 64'd3);
        repeat (20) @(posedge clock);
        #1 resetn = 1'b0;
        @(posedge clock); #1;
        resetn = 1'b1;
        compared++; if ({m_axis_dout_tvalid, s_axis_divisor_tready, s_axis_dividend_tready} !== 3'b011) begin mismatched++; $display("FAIL mreset_flags got=%b want=011", {m_axis_dout_tvalid, s_axis_divisor_tready, s_axis_dividend_tready}); end
        compared++; if (m_axis_dout_tdata !== '0) begin mismatched++; $display("FAIL mreset_tdata got=%h want=0", m_axis_dout_tdata); end
        for (int i = 0; i < 100; i++) begin
            @(posedge clock); #1;
            if (m_axis_dout_tvalid !== 1'b0) stale++;
        end
        compared++; if (stale !== 0) begin mismatched++; $display("FAIL mreset_stale got=%0d valid cycles want=0", stale); end
        send_both(64'd50, 64'd5);
        wait_valid(lat);
        compared++; if (lat !== 65) begin mismatched++; $display("FAIL mreset_recover_latency got=%0d want=65", lat); end
        compared++; if (m_axis_dout_tdata !== exp) begin mismatched++; $display("FAIL mreset_recover_tdata got=%h want=%h", m_axis_dout_tdata, exp); end
        consume();
    endtask

    initial begin
        resetn                 = 1'b0;
        s_axis_divisor_tvalid  = 1'b0;
        s_axis_divisor_tdata   = '0;
        s_axis_dividend_tvalid = 1'b0;
        s_axis_dividend_tdata  = '0;
        m_axis_dout_tready     = 1'b0;
        test_reset();
        test_basic();
        test_vectors();
        test_div_zero();
        test_back_to_back();
        test_backpressure();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
